// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the instruction phase sequencer.
package phase_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int DEF_NUM_PHASES = 5;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_EXEC   = 3'd2;
    localparam logic [2:0] PH_MEM    = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;

endpackage

// File: rtl/phase_sequencer_btn_sync_edge.sv
// Raw push-button synchronizer followed by a registered rising-edge detector.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn};
            prev  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: run/stop, single step and halt at instruction boundaries.
//
// state  | meaning
// IDLE   | stopped at a boundary, phase held at 0
// RUN    | free-running instructions until stop request or halt
// STEP   | executing exactly one instruction, then back to IDLE
// HALTED | datapath halt seen at a boundary, waiting for exec
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_PHASES  = DEF_NUM_PHASES,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  step,
    input  logic                  halt,
    input  logic                  stall,
    output logic [2:0]            phase,
    output logic [NUM_PHASES-1:0] p_en,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

    state_t state;
    logic   stop_req;
    logic   exec_pulse;
    logic   step_pulse;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
        .clock (clock),
        .reset (reset),
        .btn   (exec),
        .pulse (exec_pulse)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clock (clock),
        .reset (reset),
        .btn   (step),
        .pulse (step_pulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 3'd0;
            running     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            stop_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= 3'd0;
                    if (exec_pulse) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (step_pulse) begin
                        state   <= STEP;
                        running <= 1'b1;
                    end
                end
                RUN, STEP: begin
                    if (state == RUN && exec_pulse)
                        stop_req <= 1'b1;
                    if (!stall) begin
                        if (phase == LAST_PHASE) begin
                            instr_count <= instr_count + CNT_W'(1);
                            phase       <= 3'd0;
                            // A late exec pulse still stops at this same boundary.
                            if (halt) begin
                                state    <= HALTED;
                                running  <= 1'b0;
                                halted   <= 1'b1;
                                stop_req <= 1'b0;
                            end else if (state == STEP || stop_req || exec_pulse) begin
                                state    <= IDLE;
                                running  <= 1'b0;
                                stop_req <= 1'b0;
                            end
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                end
                HALTED: begin
                    phase <= 3'd0;
                    if (exec_pulse) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    phase   <= 3'd0;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    // Decoded only from registered state and the synchronous stall, so glitch-free.
    always_comb begin
        p_en = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (running && !stall && phase == 3'(i))
                p_en[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (plus a CNT_W=4 copy for wrap).
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exec  = 1'b0;
    logic        step  = 1'b0;
    logic        halt  = 1'b0;
    logic        stall = 1'b0;

    logic [2:0]  phase;
    logic [4:0]  p_en;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    logic [2:0]  phase4;
    logic [4:0]  p_en4;
    logic        running4;
    logic        halted4;
    logic [3:0]  instr_count4;

    int checks   = 0;
    int failures = 0;

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step        (step),
        .halt        (halt),
        .stall       (stall),
        .phase       (phase),
        .p_en        (p_en),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step        (step),
        .halt        (halt),
        .stall       (stall),
        .phase       (phase4),
        .p_en        (p_en4),
        .running     (running4),
        .halted      (halted4),
        .instr_count (instr_count4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        halt;
        logic        stall;
        logic [2:0]  ph;
        logic [4:0]  pen;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Hold the raw button(s) 3 cycles, release, and let the pulse act.
    task automatic press(input logic e, input logic s);
        exec = e;
        step = s;
        tick(3);
        exec = 1'b0;
        step = 1'b0;
        tick(3);
    endtask

    task automatic check_state(input string name, input logic [2:0] ph, input logic run,
                               input logic hlt, input logic [15:0] cnt);
        check({name, ".phase"}, 32'(phase), 32'(ph));
        check({name, ".running"}, 32'(running), 32'(run));
        check({name, ".halted"}, 32'(halted), 32'(hlt));
        check({name, ".count"}, 32'(instr_count), 32'(cnt));
    endtask

    initial begin
        int pen_cycles;

        //            halt  stall ph    pen       run   hlt   cnt
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 5'b00000, 1'b1, 1'b0, 16'd2};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0, 16'd2};
        vecs[12] = '{1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0, 16'd2};
        vecs[15] = '{1'b1, 1'b1, 3'd4, 5'b00000, 1'b1, 1'b0, 16'd2};
        vecs[16] = '{1'b1, 1'b1, 3'd4, 5'b00000, 1'b1, 1'b0, 16'd2};
        vecs[17] = '{1'b1, 1'b1, 3'd4, 5'b00000, 1'b1, 1'b0, 16'd2};
        vecs[18] = '{1'b1, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0, 16'd2};
        vecs[19] = '{1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b1, 16'd3};

        tick(3);
        @(negedge clock);
        reset = 1'b0;
        tick(1);
        check_state("reset", 3'd0, 1'b0, 1'b0, 16'd0);
        check("reset.p_en", 32'(p_en), 32'd0);

        // Held exec: RUN four edges after the raw rise, and only one pulse.
        exec = 1'b1;
        tick(3);
        check("exec_latency.idle", 32'(running), 32'd0);
        tick(1);

        for (int i = 0; i < 20; i++) begin
            halt  = vecs[i].halt;
            stall = vecs[i].stall;
            #1;
            check($sformatf("vec%0d.phase", i), 32'(phase), 32'(vecs[i].ph));
            check($sformatf("vec%0d.p_en", i), 32'(p_en), 32'(vecs[i].pen));
            check($sformatf("vec%0d.running", i), 32'(running), 32'(vecs[i].run));
            check($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("vec%0d.count", i), 32'(instr_count), 32'(vecs[i].cnt));
            tick(1);
        end
        exec  = 1'b0;
        halt  = 1'b0;
        stall = 1'b0;
        tick(2);

        press(1'b0, 1'b1);
        check_state("halted_step_ignored", 3'd0, 1'b0, 1'b1, 16'd3);
        press(1'b1, 1'b0);
        check_state("halted_exec_idle", 3'd0, 1'b0, 1'b0, 16'd3);
        press(1'b1, 1'b0);
        check_state("resume_run", 3'd2, 1'b1, 1'b0, 16'd3);

        // Stop request landing in phase 2: phases 3 and 4 still complete.
        tick(2);
        check_state("stop_mid.pre", 3'd4, 1'b1, 1'b0, 16'd3);
        exec = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick(1);
            if (p == 2) exec = 1'b0;
            check_state($sformatf("stop_mid.ph%0d", p), 3'(p), 1'b1, 1'b0, 16'd4);
        end
        tick(1);
        check_state("stop_mid.idle", 3'd0, 1'b0, 1'b0, 16'd5);

        // Stop pulse arriving in the last phase takes effect at that boundary.
        press(1'b1, 1'b0);
        tick(4);
        check_state("stop_last.pre", 3'd1, 1'b1, 1'b0, 16'd6);
        exec = 1'b1;
        tick(3);
        exec = 1'b0;
        check_state("stop_last.ph4", 3'd4, 1'b1, 1'b0, 16'd6);
        tick(1);
        check_state("stop_last.idle", 3'd0, 1'b0, 1'b0, 16'd7);

        // Step held for 50 cycles: exactly one instruction.
        pen_cycles = 0;
        step = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (p_en != 5'd0) pen_cycles++;
        end
        step = 1'b0;
        check("step.pen_cycles", 32'(pen_cycles), 32'd5);
        check_state("step.done", 3'd0, 1'b0, 1'b0, 16'd8);

        // exec and step together: exec wins, so it keeps running past one instruction.
        press(1'b1, 1'b1);
        check_state("both.start", 3'd2, 1'b1, 1'b0, 16'd8);
        tick(10);
        check_state("both.still_run", 3'd2, 1'b1, 1'b0, 16'd10);

        // Asynchronous reset at phase 3, checked before the next clock edge.
        tick(1);
        check_state("abort.pre", 3'd3, 1'b1, 1'b0, 16'd10);
        #2 reset = 1'b1;
        #1;
        check_state("abort", 3'd0, 1'b0, 1'b0, 16'd0);
        check("abort.p_en", 32'(p_en), 32'd0);
        check("abort.count4", 32'(instr_count4), 32'd0);
        tick(2);
        @(negedge clock);
        reset = 1'b0;
        tick(1);

        // 17 instructions: 16-bit copy reads 17, 4-bit copy wraps to 1.
        press(1'b1, 1'b0);
        check_state("wrap.start", 3'd2, 1'b1, 1'b0, 16'd0);
        tick(83);
        check_state("wrap.end", 3'd0, 1'b1, 1'b0, 16'd17);
        check("wrap.count4", 32'(instr_count4), 32'd1);
        check("wrap.running4", 32'(running4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
